// File: rtl/plate_manager.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | plate_manager: pool of tracked plates with debounced E-key pickup/drop,   |
// | stove fill and vent delivery scoring.            Revision: 1.0            |
// +--------------------------------------------------------------------------+
module plate_manager #(
  parameter int         NUM_PLATES      = 4,
  parameter int         ID_W            = 3,
  parameter int         COORD_W         = 10,
  parameter int         SCORE_W         = 4,
  parameter int         DEBOUNCE_FRAMES = 3,
  parameter int         HOLD_OFFSET     = 20,
  parameter int         HOME_X          = 20,
  parameter int         HOME_Y          = 260,
  parameter int         HOME_STEP       = 24,
  parameter logic [7:0] KEY_ACT         = 8'h08
) (
  input  logic                          frame_clk,
  input  logic                          Reset,
  input  logic [7:0]                    keycode,
  input  logic                          wallFlag,
  input  logic [3:0]                    tileType,
  input  logic [1:0]                    potState,
  input  logic [1:0]                    orderType,
  input  logic [COORD_W-1:0]            penguinX,
  input  logic [COORD_W-1:0]            penguinY,
  input  logic [COORD_W-1:0]            nearestCounterX,
  input  logic [COORD_W-1:0]            nearestCounterY,
  input  logic                          nearestPlateValid,
  input  logic [ID_W-1:0]               nearestPlateId,
  output logic [NUM_PLATES*COORD_W-1:0] plateX,
  output logic [NUM_PLATES*COORD_W-1:0] plateY,
  output logic [NUM_PLATES*2-1:0]       plateState,
  output logic                          heldValid,
  output logic [ID_W-1:0]               heldId,
  output logic [SCORE_W-1:0]            score,
  output logic                          scoreStrobe,
  output logic                          missStrobe,
  output logic                          potTake
);

  localparam int         LOCK_W       = (DEBOUNCE_FRAMES < 1) ? 1 : $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [3:0] TILE_COUNTER = 4'd1;
  localparam logic [3:0] TILE_STOVE   = 4'd3;
  localparam logic [3:0] TILE_VENT    = 4'd8;

  typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t              state, state_next;
  logic                key_prev;
  logic [LOCK_W-1:0]   lock;
  logic                key_now, act;
  logic [1:0]          held_st;
  logic                pickup, drop, fill, deliver, deliver_ok;
  logic [COORD_W-1:0]  px  [NUM_PLATES];
  logic [COORD_W-1:0]  py  [NUM_PLATES];
  logic [1:0]          pst [NUM_PLATES];
  logic [COORD_W-1:0]  follow_x, follow_y;

  assign key_now  = (keycode == KEY_ACT);
  assign act      = key_now && !key_prev && (lock == '0);
  assign follow_x = penguinX + COORD_W'(HOLD_OFFSET);
  assign follow_y = penguinY + COORD_W'(HOLD_OFFSET);

  always_comb begin
    held_st = 2'd0;
    for (int k = 0; k < NUM_PLATES; k++) begin
      if (heldId == ID_W'(k)) held_st = pst[k];
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // The FSM state alone decides whether an accepted action is a pickup or a drop.
  always_comb begin
    state_next = state;
    pickup     = 1'b0;
    drop       = 1'b0;
    fill       = 1'b0;
    deliver    = 1'b0;
    deliver_ok = 1'b0;
    case (state)
      IDLE: begin
        if (act && wallFlag && nearestPlateValid && (32'(nearestPlateId) < NUM_PLATES)) begin
          pickup     = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (act && wallFlag) begin
          case (tileType)
            TILE_COUNTER: begin
              if (!nearestPlateValid) begin
                drop       = 1'b1;
                state_next = IDLE;
              end
            end
            TILE_STOVE: fill = (potState != 2'd0) && (held_st == 2'd0);
            TILE_VENT: begin
              deliver    = 1'b1;
              deliver_ok = (held_st != 2'd0) && (held_st == orderType);
              state_next = IDLE;
            end
            default: ;
          endcase
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      key_prev    <= 1'b0;
      lock        <= '0;
      heldValid   <= 1'b0;
      heldId      <= '0;
      score       <= '0;
      scoreStrobe <= 1'b0;
      missStrobe  <= 1'b0;
      potTake     <= 1'b0;
    end else begin
      key_prev    <= key_now;
      scoreStrobe <= deliver_ok;
      missStrobe  <= deliver && !deliver_ok;
      potTake     <= fill;
      if (act)               lock <= LOCK_W'(DEBOUNCE_FRAMES);
      else if (lock != '0)   lock <= lock - LOCK_W'(1);
      if (pickup) begin
        heldValid <= 1'b1;
        heldId    <= nearestPlateId;
      end else if (drop || deliver) begin
        heldValid <= 1'b0;
      end
      if (deliver_ok && (score != '1)) score <= score + SCORE_W'(1);
    end
  end

  // Only the held plate ever changes; every other plate keeps its registers.
  always_ff @(posedge frame_clk) begin
    for (int i = 0; i < NUM_PLATES; i++) begin
      if (Reset) begin
        px[i]  <= COORD_W'(HOME_X + i * HOME_STEP);
        py[i]  <= COORD_W'(HOME_Y);
        pst[i] <= 2'd0;
      end else if ((state == HOLD) && (heldId == ID_W'(i))) begin
        if (deliver) begin
          px[i]  <= COORD_W'(HOME_X + i * HOME_STEP);
          py[i]  <= COORD_W'(HOME_Y);
          pst[i] <= 2'd0;
        end else if (drop) begin
          px[i] <= nearestCounterX;
          py[i] <= nearestCounterY;
        end else begin
          px[i] <= follow_x;
          py[i] <= follow_y;
          if (fill) pst[i] <= potState;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_PLATES; g++) begin : g_pack
    assign plateX[g*COORD_W +: COORD_W] = px[g];
    assign plateY[g*COORD_W +: COORD_W] = py[g];
    assign plateState[g*2 +: 2]         = pst[g];
  end

endmodule
`default_nettype wire

// File: tb/tb_plate_manager.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_plate_manager: directed and random stimulus against a frame-level     |
// | reference model of the plate pool.               Revision: 1.0            |
// +--------------------------------------------------------------------------+
module tb_plate_manager;
  localparam int NP = 4, IDW = 3, CW = 10, SW = 4;

  logic          frame_clk = 1'b0;
  logic          Reset;
  logic [7:0]    keycode;
  logic          wallFlag;
  logic [3:0]    tileType;
  logic [1:0]    potState, orderType;
  logic [CW-1:0] penguinX, penguinY, nearestCounterX, nearestCounterY;
  logic          nearestPlateValid;
  logic [IDW-1:0] nearestPlateId;
  logic [NP*CW-1:0] plateX, plateY;
  logic [NP*2-1:0]  plateState;
  logic          heldValid;
  logic [IDW-1:0] heldId;
  logic [SW-1:0] score;
  logic          scoreStrobe, missStrobe, potTake;

  plate_manager #(.NUM_PLATES(NP), .ID_W(IDW), .COORD_W(CW), .SCORE_W(SW)) dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .wallFlag(wallFlag),
    .tileType(tileType), .potState(potState), .orderType(orderType),
    .penguinX(penguinX), .penguinY(penguinY),
    .nearestCounterX(nearestCounterX), .nearestCounterY(nearestCounterY),
    .nearestPlateValid(nearestPlateValid), .nearestPlateId(nearestPlateId),
    .plateX(plateX), .plateY(plateY), .plateState(plateState),
    .heldValid(heldValid), .heldId(heldId), .score(score),
    .scoreStrobe(scoreStrobe), .missStrobe(missStrobe), .potTake(potTake)
  );

  always #5 frame_clk = ~frame_clk;

  int n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference model: per-plate arrays plus the frame index of the last accepted action.
  int m_x[NP], m_y[NP], m_st[NP];
  bit m_held, m_keyprev, m_ss, m_ms, m_pt;
  int m_id, m_score, m_last, m_frame = 0;

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_x[i] = 20 + 24 * i; m_y[i] = 260; m_st[i] = 0;
    end
    m_held = 0; m_id = 0; m_score = 0; m_keyprev = 0;
    m_ss = 0; m_ms = 0; m_pt = 0;
    m_last = m_frame - 1000;
  endtask

  task automatic model_edge();
    bit key, act, leave;
    int h;
    m_frame++;
    if (Reset) begin
      model_reset();
      return;
    end
    key = (keycode == 8'h08);
    act = key && !m_keyprev && (m_frame - m_last > 3);
    m_keyprev = key;
    m_ss = 0; m_ms = 0; m_pt = 0;
    if (act) m_last = m_frame;
    if (!m_held) begin
      if (act && wallFlag && nearestPlateValid && int'(nearestPlateId) < NP) begin
        m_held = 1; m_id = int'(nearestPlateId);
      end
    end else begin
      h = m_id; leave = 0;
      if (act && wallFlag) begin
        if (tileType == 4'd1 && !nearestPlateValid) begin
          m_x[h] = int'(nearestCounterX); m_y[h] = int'(nearestCounterY);
          leave = 1;
        end else if (tileType == 4'd3 && potState != 0 && m_st[h] == 0) begin
          m_st[h] = int'(potState); m_pt = 1;
        end else if (tileType == 4'd8) begin
          if (m_st[h] != 0 && m_st[h] == int'(orderType)) begin
            if (m_score < 15) m_score++;
            m_ss = 1;
          end else m_ms = 1;
          m_x[h] = 20 + 24 * h; m_y[h] = 260; m_st[h] = 0;
          leave = 1;
        end
      end
      if (leave) m_held = 0;
      else begin
        m_x[h] = (int'(penguinX) + 20) % 1024;
        m_y[h] = (int'(penguinY) + 20) % 1024;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NP; i++) begin
      check($sformatf("x%0d", i), int'(plateX[i*CW +: CW]), m_x[i]);
      check($sformatf("y%0d", i), int'(plateY[i*CW +: CW]), m_y[i]);
      check($sformatf("st%0d", i), int'(plateState[i*2 +: 2]), m_st[i]);
    end
    check("heldValid", int'(heldValid), int'(m_held));
    check("heldId", int'(heldId), m_id);
    check("score", int'(score), m_score);
    check("scoreStrobe", int'(scoreStrobe), int'(m_ss));
    check("missStrobe", int'(missStrobe), int'(m_ms));
    check("potTake", int'(potTake), int'(m_pt));
  endtask

  task automatic step();
    @(posedge frame_clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    keycode = 8'h00;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press();
    keycode = 8'h08;
    step();
    keycode = 8'h00;
  endtask

  task automatic pick(input int id);
    nearestPlateValid = 1'b1; nearestPlateId = IDW'(id); tileType = 4'd0;
    press(); idle(4);
  endtask

  task automatic fill(input int pot);
    tileType = 4'd3; potState = 2'(pot);
    press(); idle(4);
  endtask

  initial begin
    Reset = 1'b1; keycode = 8'h00; wallFlag = 1'b0; tileType = 4'd0;
    potState = 2'd0; orderType = 2'd0; penguinX = '0; penguinY = '0;
    nearestCounterX = '0; nearestCounterY = '0;
    nearestPlateValid = 1'b0; nearestPlateId = '0;
    model_reset();
    step(); step();
    for (int i = 0; i < NP; i++) check("reset_home_x", int'(plateX[i*CW +: CW]), 20 + 24 * i);
    check("reset_home_y3", int'(plateY[3*CW +: CW]), 260);
    check("reset_states", int'(plateState), 0);
    check("reset_score", int'(score), 0);
    check("reset_held", int'(heldValid), 0);
    Reset = 1'b0;
    idle(2);

    // Pickup and follow
    wallFlag = 1'b1; nearestPlateValid = 1'b1; nearestPlateId = 3'd2;
    press();
    check("pick_held", int'(heldValid), 1);
    check("pick_id", int'(heldId), 2);
    penguinX = 10'd100; penguinY = 10'd50;
    step();
    check("follow_x", int'(plateX[2*CW +: CW]), 120);
    check("follow_y", int'(plateY[2*CW +: CW]), 70);
    idle(4);

    // Debounce: long hold, then a blocked re-press and an accepted one
    keycode = 8'h08;
    for (int i = 0; i < 10; i++) step();
    idle(5);
    tileType = 4'd0; keycode = 8'h08; step();
    keycode = 8'h00; step();
    tileType = 4'd3; potState = 2'd2; keycode = 8'h08; step();
    check("blocked_state", int'(plateState[2*2 +: 2]), 0);
    check("blocked_pot", int'(potTake), 0);
    keycode = 8'h00; step();
    keycode = 8'h08; step();
    check("fill_state", int'(plateState[2*2 +: 2]), 2);
    check("fill_pot", int'(potTake), 1);
    keycode = 8'h00; step();
    check("fill_pot_off", int'(potTake), 0);
    idle(4);
    potState = 2'd1; press();
    check("refill_state", int'(plateState[2*2 +: 2]), 2);
    check("refill_pot", int'(potTake), 0);
    idle(4);

    // Deliveries
    orderType = 2'd2; tileType = 4'd8; press();
    check("deliv_score", int'(score), 1);
    check("deliv_strobe", int'(scoreStrobe), 1);
    check("deliv_home_x", int'(plateX[2*CW +: CW]), 68);
    check("deliv_home_y", int'(plateY[2*CW +: CW]), 260);
    check("deliv_state", int'(plateState[2*2 +: 2]), 0);
    check("deliv_held", int'(heldValid), 0);
    step();
    check("deliv_strobe_off", int'(scoreStrobe), 0);
    idle(4);
    pick(1); fill(1);
    tileType = 4'd8; press();
    check("miss_strobe", int'(missStrobe), 1);
    check("miss_score", int'(score), 1);
    idle(4);
    for (int n = 0; n < 15; n++) begin
      pick(0); fill(2);
      tileType = 4'd8; press();
      idle(4);
    end
    check("sat_score", int'(score), 15);

    // Counter rules
    pick(3);
    tileType = 4'd1; nearestPlateValid = 1'b1; press();
    check("counter_occupied", int'(heldValid), 1);
    idle(4);
    nearestPlateValid = 1'b0; nearestCounterX = 10'd300; nearestCounterY = 10'd120;
    press();
    check("counter_x", int'(plateX[3*CW +: CW]), 300);
    check("counter_y", int'(plateY[3*CW +: CW]), 120);
    check("counter_idle", int'(heldValid), 0);
    idle(4);

    // Reset mid-hold and mid-lockout
    pick(1); fill(2);
    tileType = 4'd0; press();
    Reset = 1'b1; step(); step();
    check("rst_x1", int'(plateX[1*CW +: CW]), 44);
    check("rst_state", int'(plateState), 0);
    check("rst_score", int'(score), 0);
    check("rst_held", int'(heldValid), 0);
    check("rst_heldId", int'(heldId), 0);
    Reset = 1'b0;

    // Random stimulus against the model
    for (int n = 0; n < 700; n++) begin
      int sel;
      Reset = ($urandom_range(0, 120) == 0);
      sel = $urandom_range(0, 3);
      keycode = (sel == 3) ? 8'h1c : ((sel == 0) ? 8'h00 : 8'h08);
      if ($urandom_range(0, 1) == 0) keycode = 8'h00;
      wallFlag = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 4);
      tileType = (sel == 0) ? 4'd1 : (sel == 1) ? 4'd3 : (sel == 2) ? 4'd8 : (sel == 3) ? 4'd0 : 4'd5;
      potState = 2'($urandom_range(0, 3));
      orderType = 2'($urandom_range(0, 3));
      penguinX = CW'($urandom); penguinY = CW'($urandom);
      nearestCounterX = CW'($urandom); nearestCounterY = CW'($urandom);
      nearestPlateValid = ($urandom_range(0, 2) != 0);
      nearestPlateId = IDW'($urandom_range(0, 5));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
